pc_sequencer: RTL and testbench

Multi-cycle program-counter and instruction-fetch sequencer for the single-issue MIPS-subset core. It owns the PC register and fetches instruction words through a req/ack instruction-memory port. It holds each word stable for the control decoder until the datapath commits, then consumes the decoder's PCSrc/JT/Imm16 outputs plus the branch result to select the next PC. It also gates and delivers the pending interrupt request to the decoder.

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register and two-state req/ack instruction-fetch sequencer.
// Build macro PC_SUPERVISOR_EN makes pc[31] a kernel-mode bit that masks IRQ and guards mode changes.
module pc_sequencer (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] instruction,
   output logic        inst_valid,
   input  logic        commit,
   input  logic [2:0]  pc_src,
   input  logic [25:0] jt,
   input  logic [15:0] imm16,
   input  logic        branch_taken,
   input  logic [31:0] jr_target,
   input  logic        irq_in,
   output logic        irq_out,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] ILLOP    = 32'h8000_0004;
   localparam logic [31:0] XADR     = 32'h8000_0008;

   typedef enum logic [2:0] {
      SRC_SEQ    = 3'd0,
      SRC_BRANCH = 3'd1,
      SRC_JUMP   = 3'd2,
      SRC_JR     = 3'd3,
      SRC_IRQ    = 3'd4,
      SRC_EXC    = 3'd5
   } pc_src_e;

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } state_e;

   state_e      state;
   logic        irq_pend;
   logic        mask;
   logic        commit_now;
   logic [31:0] branch_off;
   logic [31:0] next_pc;

`ifdef PC_SUPERVISOR_EN
   // The kernel bit survives sequential increment; only the low 31 bits count.
   assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};
   assign mask     = pc[31];
`else
   assign pc_plus4 = pc + 32'd4;
   assign mask     = 1'b0;
`endif

   assign imem_addr  = pc;
   assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};
   assign commit_now = (state == ISSUE) && commit;
   assign irq_out    = irq_pend & inst_valid & ~mask;

   always_comb begin
      // NOTE: default assigned first so every path writes next_pc and no latch is inferred.
      next_pc = XADR;
      case (pc_src)
         SRC_SEQ:    next_pc = pc_plus4;
         SRC_BRANCH: next_pc = branch_taken ? pc_plus4 + branch_off : pc_plus4;
         SRC_JUMP:   next_pc = {pc_plus4[31:28], jt, 2'b00};
         SRC_JR:     next_pc = jr_target;
         SRC_IRQ:    next_pc = ILLOP;
         default:    next_pc = XADR;
      endcase
`ifdef PC_SUPERVISOR_EN
      if (pc_src == SRC_BRANCH || pc_src == SRC_JUMP)
         next_pc[31] = pc[31];
      else if (pc_src == SRC_JR)
         next_pc[31] = pc[31] & jr_target[31];
`endif
   end

   // imem_req is held low for one cycle after reset, so a stale ack cannot be taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: non-blocking assignments so all flops update from pre-edge values.
         state       <= FETCH;
         pc          <= RESET_PC;
         instruction <= '0;
         inst_valid  <= 1'b0;
         imem_req    <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  instruction <= imem_data;
                  imem_req    <= 1'b0;
                  inst_valid  <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (commit) begin
                  pc         <= next_pc;
                  inst_valid <= 1'b0;
                  imem_req   <= 1'b1;
                  state      <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   // Clear beats set: a level still high re-arms the pending bit one cycle later.
   always_ff @(posedge clk) begin
      if (reset)
         irq_pend <= 1'b0;
      else if (commit_now && pc_src == SRC_IRQ)
         irq_pend <= 1'b0;
      else if (irq_in)
         irq_pend <= 1'b1;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan cases plus randomized transactions against a
// transaction-level reference model of pc_sequencer (honours PC_SUPERVISOR_EN).
module tb_pc_sequencer;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] ILLOP    = 32'h8000_0004;
   localparam logic [31:0] XADR     = 32'h8000_0008;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instruction;
   logic        inst_valid;
   logic        commit;
   logic [2:0]  pc_src;
   logic [25:0] jt;
   logic [15:0] imm16;
   logic        branch_taken;
   logic [31:0] jr_target;
   logic        irq_in;
   logic        irq_out;
   logic [31:0] pc;
   logic [31:0] pc_plus4;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_pc;
   logic        m_pend;
   logic        issue_irq_seen;

   pc_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_data    (imem_data),
      .instruction  (instruction),
      .inst_valid   (inst_valid),
      .commit       (commit),
      .pc_src       (pc_src),
      .jt           (jt),
      .imm16        (imm16),
      .branch_taken (branch_taken),
      .jr_target    (jr_target),
      .irq_in       (irq_in),
      .irq_out      (irq_out),
      .pc           (pc),
      .pc_plus4     (pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit sup();
`ifdef PC_SUPERVISOR_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Link value: pc + 4, with the kernel bit carried over unchanged in supervisor builds.
   function automatic logic [31:0] model_plus4(input logic [31:0] p);
      logic [31:0] r;
      r = p + 32'd4;
      if (sup())
         r = (r & 32'h7FFF_FFFF) | (p & 32'h8000_0000);
      return r;
   endfunction

   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [2:0] src,
                                              input logic [25:0] j, input logic [15:0] im,
                                              input logic bt, input logic [31:0] jr);
      logic [31:0] p4;
      logic [31:0] r;
      int          off;
      p4  = model_plus4(p);
      off = int'($signed(im)) * 4;
      case (src)
         3'd0:    r = p4;
         3'd1:    r = bt ? p4 + 32'(off) : p4;
         3'd2:    r = (p4 & 32'hF000_0000) | (32'(j) * 32'd4);
         3'd3:    r = jr;
         3'd4:    r = ILLOP;
         default: r = XADR;
      endcase
      if (sup()) begin
         if (src == 3'd1 || src == 3'd2)
            r = (r & 32'h7FFF_FFFF) | (p & 32'h8000_0000);
         else if (src == 3'd3)
            r = (r & 32'h7FFF_FFFF) | (p & jr & 32'h8000_0000);
      end
      return r;
   endfunction

   function automatic logic irq_drive(input int pat, input bit first);
      case (pat)
         1:       return first;
         2:       return 1'($urandom_range(0, 1));
         3:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // One clock; the pending-interrupt model follows the set/clear rules at the edge.
   task automatic tick(input bit clr);
      logic nxt;
      nxt = reset ? 1'b0 : (clr ? 1'b0 : (irq_in ? 1'b1 : m_pend));
      @(posedge clk);
      #1;
      m_pend = nxt;
   endtask

   task automatic randomize_ctrl();
      pc_src       = 3'($urandom_range(0, 7));
      jt           = 26'($urandom);
      imm16        = 16'($urandom);
      branch_taken = 1'($urandom_range(0, 1));
      jr_target    = $urandom;
   endtask

   task automatic apply_reset();
      reset    = 1'b1;
      imem_ack = 1'($urandom_range(0, 1));
      commit   = 1'b1;
      irq_in   = 1'($urandom_range(0, 1));
      tick(1'b0);
      reset = 1'b0;
      m_pc  = RESET_PC;
      check("rst_pc", pc, RESET_PC);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_irq_out", 32'(irq_out), 32'd0);
      check("rst_instr", instruction, 32'd0);
      // A late ack and a stray commit in the quiet cycle must both be ignored.
      imem_ack  = 1'b1;
      imem_data = $urandom;
      commit    = 1'b1;
      irq_in    = 1'b0;
      tick(1'b0);
   endtask

   // One instruction: fetch with wait states, issue with stalls, then commit.
   // abort: 0 none, 1 reset during fetch, 2 reset during issue.
   task automatic run_insn(input int waits, input int stalls, input logic [31:0] word,
                           input logic [2:0] src, input logic [25:0] j, input logic [15:0] im,
                           input logic bt, input logic [31:0] jr, input int irq_pat,
                           input int abort);
      logic [31:0] exp_pc;
      bit          last;
      for (int w = 0; w <= waits; w++) begin
         check("fetch_req", 32'(imem_req), 32'd1);
         check("fetch_addr", imem_addr, m_pc);
         check("fetch_pc", pc, m_pc);
         check("fetch_valid", 32'(inst_valid), 32'd0);
         check("fetch_irq_out", 32'(irq_out), 32'd0);
         check("pc_plus4", pc_plus4, model_plus4(m_pc));
         if (abort == 1) begin
            apply_reset();
            return;
         end
         imem_ack  = (w == waits);
         imem_data = (w == waits) ? word : $urandom;
         commit    = 1'b1;
         randomize_ctrl();
         irq_in    = irq_drive(irq_pat, w == 0);
         tick(1'b0);
      end
      for (int s = 0; s <= stalls; s++) begin
         last = (s == stalls);
         check("issue_valid", 32'(inst_valid), 32'd1);
         check("issue_instr", instruction, word);
         check("issue_req", 32'(imem_req), 32'd0);
         check("issue_pc", pc, m_pc);
         check("issue_irq_out", 32'(irq_out), 32'(m_pend && !(sup() && m_pc[31])));
         if (s == 0)
            issue_irq_seen = irq_out;
         if (last && abort == 2) begin
            apply_reset();
            return;
         end
         imem_ack  = 1'($urandom_range(0, 1));
         imem_data = $urandom;
         irq_in    = irq_drive(irq_pat, 1'b0);
         commit    = last;
         if (last) begin
            pc_src = src; jt = j; imm16 = im; branch_taken = bt; jr_target = jr;
         end else begin
            randomize_ctrl();
         end
         tick(last && src == 3'd4);
      end
      exp_pc = model_next(m_pc, src, j, im, bt, jr);
      m_pc   = exp_pc;
      check("commit_pc", pc, m_pc);
      check("commit_valid", 32'(inst_valid), 32'd0);
      check("commit_req", 32'(imem_req), 32'd1);
      commit = 1'b0;
   endtask

   task automatic step(input logic [2:0] src, input logic [25:0] j, input logic [15:0] im,
                       input logic bt, input logic [31:0] jr);
      run_insn(0, 0, $urandom, src, j, im, bt, jr, 0, 0);
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_data = '0; commit = 1'b0; pc_src = '0;
      jt = '0; imm16 = '0; branch_taken = 1'b0; jr_target = '0; irq_in = 1'b0;
      m_pc = RESET_PC; m_pend = 1'b0; issue_irq_seen = 1'b0;

      apply_reset();
      run_insn(0, 0, 32'h2008_0005, 3'd0, '0, '0, 1'b0, '0, 0, 0);
      check("tp_first_seq", pc, 32'h8000_0004);
      for (int i = 0; i < 3; i++) step(3'd0, '0, '0, 1'b0, '0);
      check("tp_pc_8000_0010", pc, 32'h8000_0010);
      step(3'd2, 26'h000_0040, '0, 1'b0, '0);
      check("tp_jump", pc, 32'h8000_0100);
      step(3'd3, '0, '0, 1'b0, 32'h0000_0200);
      check("tp_jr", pc, 32'h0000_0200);
      step(3'd3, '0, '0, 1'b0, 32'h8000_0000);
`ifdef PC_SUPERVISOR_EN
      check("tp_jr_user", pc, 32'h0000_0000);
`else
      check("tp_jr_user", pc, 32'h8000_0000);
`endif
      step(3'd3, '0, '0, 1'b0, 32'h0000_0100);
      step(3'd1, '0, 16'hFFFE, 1'b1, '0);
      check("tp_branch_taken", pc, 32'h0000_00FC);
      step(3'd3, '0, '0, 1'b0, 32'h0000_0100);
      step(3'd1, '0, 16'hFFFE, 1'b0, '0);
      check("tp_branch_not_taken", pc, 32'h0000_0104);

      step(3'd3, '0, '0, 1'b0, 32'h0000_0040);
      run_insn(1, 1, $urandom, 3'd4, '0, '0, 1'b0, '0, 1, 0);
      check("tp_irq_out_user", 32'(issue_irq_seen), 32'd1);
      check("tp_irq_vector", pc, 32'h8000_0004);
      check("tp_irq_cleared", 32'(irq_out), 32'd0);
      step(3'd2, 26'h000_0014, '0, 1'b0, '0);
      check("tp_pc_8000_0050", pc, 32'h8000_0050);
      run_insn(0, 2, $urandom, 3'd4, '0, '0, 1'b0, '0, 3, 0);
`ifdef PC_SUPERVISOR_EN
      check("tp_irq_out_kernel", 32'(issue_irq_seen), 32'd0);
`else
      check("tp_irq_out_kernel", 32'(issue_irq_seen), 32'd1);
`endif

      run_insn(3, 0, $urandom, 3'd0, '0, '0, 1'b0, '0, 0, 0);
      step(3'd3, '0, '0, 1'b0, 32'h0000_0300);
      run_insn(1, 1, $urandom, 3'd0, '0, '0, 1'b0, '0, 0, 2);
      check("tp_reset_issue_pc", pc, 32'h8000_0000);
      step(3'd6, '0, '0, 1'b0, '0);
      check("tp_src6", pc, 32'h8000_0008);
      run_insn(2, 0, $urandom, 3'd0, '0, '0, 1'b0, '0, 0, 1);

      for (int n = 0; n < 300; n++) begin
         int abort;
         abort = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 2)) : 0;
         run_insn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom,
                  3'($urandom_range(0, 7)), 26'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), $urandom, 2, abort);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
